l2_mesi_tag_controller: RTL

- Clocked, parametrised successor to the behavioural L2 model.
- Holds tag, MESI state and true-LRU state for a WAYS-way, 2**INDEX_W-set L2 directory.
- Sits between L1 (valid/ready request, response pulse) and the shared bus (issue/grant plus snoop result); also answers snoops from other caches.
- Holds no line data: data movement is external, and this block only sequences coherence and replacement.

---
 rtl/l2_mesi_tag_controller.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/l2_mesi_tag_controller.sv
// L2 tag/MESI/true-LRU directory controller. Holds no line data; it sequences
// coherence transactions on the shared bus and answers snoops from other caches.
// Optional build macro L2_STATS_EN adds 32-bit hit/miss/read/write counters.
module l2_mesi_tag_controller #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned WAYS     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [ADDR_W-1:0]         req_addr,
    output logic                      resp_valid,
    output logic                      resp_hit,
    output logic [$clog2(WAYS)-1:0]   resp_way,
    output logic [3:0]                resp_mesi,
    output logic                      bus_valid,
    output logic [1:0]                bus_op,
    output logic [ADDR_W-1:0]         bus_addr,
    input  logic                      bus_ready,
    input  logic [1:0]                bus_snoop,
    input  logic                      snp_valid,
    output logic                      snp_ready,
    input  logic [1:0]                snp_op,
    input  logic [ADDR_W-1:0]         snp_addr,
    output logic                      snp_resp_valid,
    output logic [1:0]                snp_resp
`ifdef L2_STATS_EN
    ,
    output logic [31:0]               stat_hits,
    output logic [31:0]               stat_misses,
    output logic [31:0]               stat_reads,
    output logic [31:0]               stat_writes
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned SETS  = 1 << INDEX_W;

    // One-hot line states
    localparam logic [3:0] MESI_M = 4'b0001;
    localparam logic [3:0] MESI_E = 4'b0010;
    localparam logic [3:0] MESI_S = 4'b0100;
    localparam logic [3:0] MESI_I = 4'b1000;

    localparam logic [1:0] BUS_READ = 2'd0;
    localparam logic [1:0] BUS_RWIM = 2'd1;
    localparam logic [1:0] BUS_INV  = 2'd2;
    localparam logic [1:0] BUS_WB   = 2'd3;

    localparam logic [1:0] SNP_MISS = 2'b00;
    localparam logic [1:0] SNP_HIT  = 2'b01;
    localparam logic [1:0] SNP_HITM = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StLookup, StWriteback, StFetch, StUpgrade, StResp, StSnoop
    } state_e;

    state_e state_q;

    logic [TAG_W-1:0] tag_q  [SETS][WAYS];
    logic [3:0]       mesi_q [SETS][WAYS];
    logic [WAY_W-1:0] lru_q  [SETS][WAYS];

    logic               op_write_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic [WAY_W-1:0]   way_q;
    logic               hit_q;

    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic [3:0]       lk_state;
    logic             vic_free;
    logic [WAY_W-1:0] vic_free_way;
    logic [WAY_W-1:0] vic_lru_way;
    logic [WAY_W-1:0] victim;
    logic [3:0]       vic_state;

    logic [INDEX_W-1:0] snp_idx;
    logic [TAG_W-1:0]   snp_tag;
    logic               snp_hit;
    logic [WAY_W-1:0]   snp_way;
    logic [3:0]         snp_cur;
    logic [3:0]         snp_next;
    logic [1:0]         snp_res;

    logic unused_offsets;
    assign unused_offsets = ^{req_addr[OFFSET_W-1:0], snp_addr[OFFSET_W-1:0]};

    // A snoop in IDLE blocks the L1 request in the same cycle
    assign snp_ready = (state_q == StIdle);
    assign req_ready = (state_q == StIdle) && !snp_valid;

    assign snp_idx = snp_addr[OFFSET_W +: INDEX_W];
    assign snp_tag = snp_addr[ADDR_W-1 -: TAG_W];

    // Tag match and victim choice for the latched request
    always_comb begin
        lk_hit       = 1'b0;
        lk_way       = '0;
        vic_free     = 1'b0;
        vic_free_way = '0;
        vic_lru_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!mesi_q[req_idx_q][w][3] && tag_q[req_idx_q][w] == req_tag_q) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (lru_q[req_idx_q][w] == WAY_W'(WAYS - 1)) begin
                vic_lru_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (mesi_q[req_idx_q][w][3]) begin
                vic_free     = 1'b1;
                vic_free_way = WAY_W'(w);
            end
        end
        victim    = vic_free ? vic_free_way : vic_lru_way;
        lk_state  = mesi_q[req_idx_q][lk_way];
        vic_state = mesi_q[req_idx_q][victim];
    end

    // Snoop lookup on the incoming address and resulting response/state
    always_comb begin
        snp_hit = 1'b0;
        snp_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!mesi_q[snp_idx][w][3] && tag_q[snp_idx][w] == snp_tag) begin
                snp_hit = 1'b1;
                snp_way = WAY_W'(w);
            end
        end
        snp_cur  = mesi_q[snp_idx][snp_way];
        snp_next = snp_cur;
        snp_res  = SNP_MISS;
        if (snp_hit) begin
            unique case (snp_op)
                BUS_READ: begin
                    snp_res  = snp_cur[0] ? SNP_HITM : SNP_HIT;
                    snp_next = MESI_S;
                end
                BUS_RWIM, BUS_INV: begin
                    snp_res  = snp_cur[0] ? SNP_HITM : SNP_HIT;
                    snp_next = MESI_I;
                end
                default: begin
                    snp_res  = SNP_MISS;
                    snp_next = snp_cur;
                end
            endcase
        end
    end

    // Controller FSM, directory arrays and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            op_write_q     <= 1'b0;
            req_tag_q      <= '0;
            req_idx_q      <= '0;
            way_q          <= '0;
            hit_q          <= 1'b0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_mesi      <= '0;
            bus_valid      <= 1'b0;
            bus_op         <= '0;
            bus_addr       <= '0;
            snp_resp_valid <= 1'b0;
            snp_resp       <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    mesi_q[s][w] <= MESI_I;
                    lru_q[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            resp_valid     <= 1'b0;
            snp_resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (snp_valid) begin
                        snp_resp_valid <= 1'b1;
                        snp_resp       <= snp_res;
                        if (snp_hit) begin
                            mesi_q[snp_idx][snp_way] <= snp_next;
                        end
                        state_q <= StSnoop;
                    end else if (req_valid) begin
                        op_write_q <= (req_op == 2'd1);
                        req_tag_q  <= req_addr[ADDR_W-1 -: TAG_W];
                        req_idx_q  <= req_addr[OFFSET_W +: INDEX_W];
                        state_q    <= StLookup;
                    end
                end
                StLookup: begin
                    hit_q <= lk_hit;
                    if (lk_hit) begin
                        way_q <= lk_way;
                        if (!op_write_q || !lk_state[2]) begin
                            // Reads keep state; writes on M/E end in M without bus traffic
                            if (op_write_q) begin
                                mesi_q[req_idx_q][lk_way] <= MESI_M;
                            end
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b1;
                            resp_way   <= lk_way;
                            resp_mesi  <= op_write_q ? MESI_M : lk_state;
                            state_q    <= StResp;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_op    <= BUS_INV;
                            bus_addr  <= {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
                            state_q   <= StUpgrade;
                        end
                    end else begin
                        way_q     <= victim;
                        bus_valid <= 1'b1;
                        if (vic_state[0]) begin
                            bus_op   <= BUS_WB;
                            bus_addr <= {tag_q[req_idx_q][victim], req_idx_q, {OFFSET_W{1'b0}}};
                            state_q  <= StWriteback;
                        end else begin
                            bus_op   <= op_write_q ? BUS_RWIM : BUS_READ;
                            bus_addr <= {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
                            state_q  <= StFetch;
                        end
                    end
                end
                StWriteback: begin
                    if (bus_ready) begin
                        // bus_valid stays up: the fetch follows back to back
                        mesi_q[req_idx_q][way_q] <= MESI_I;
                        bus_op   <= op_write_q ? BUS_RWIM : BUS_READ;
                        bus_addr <= {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (bus_ready) begin
                        tag_q[req_idx_q][way_q] <= req_tag_q;
                        if (op_write_q) begin
                            mesi_q[req_idx_q][way_q] <= MESI_M;
                            resp_mesi                <= MESI_M;
                        end else if (bus_snoop != SNP_MISS) begin
                            mesi_q[req_idx_q][way_q] <= MESI_S;
                            resp_mesi                <= MESI_S;
                        end else begin
                            mesi_q[req_idx_q][way_q] <= MESI_E;
                            resp_mesi                <= MESI_E;
                        end
                        bus_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= hit_q;
                        resp_way   <= way_q;
                        state_q    <= StResp;
                    end
                end
                StUpgrade: begin
                    if (bus_ready) begin
                        mesi_q[req_idx_q][way_q] <= MESI_M;
                        bus_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= hit_q;
                        resp_way   <= way_q;
                        resp_mesi  <= MESI_M;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    // Move the accessed way to MRU; LRU stays a permutation
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == way_q) begin
                            lru_q[req_idx_q][w] <= '0;
                        end else if (lru_q[req_idx_q][w] < lru_q[req_idx_q][way_q]) begin
                            lru_q[req_idx_q][w] <= lru_q[req_idx_q][w] + 1'b1;
                        end
                    end
                    state_q <= StIdle;
                end
                StSnoop: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef L2_STATS_EN
    // Completion counters, bumped in the resp_valid cycle; wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (state_q == StResp) begin
            if (hit_q) begin
                stat_hits <= stat_hits + 32'd1;
            end else begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (op_write_q) begin
                stat_writes <= stat_writes + 32'd1;
            end else begin
                stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule
